mmio_counters: RTL and testbench

- Memory-mapped performance-counter responder on the CPU's MMIO data path.
- Answers CPU loads and stores in the 0x8000_00xx space.
- Counts clock cycles and retired instructions, with an optional branch counter pair.
- Instantiated inside cpu. Driven by the memory-stage address and strobes, plus retire pulses from writeback.

---
 rtl/mmio_counters_pkg.sv | 35 +++
 rtl/mmio_cntr.sv | 34 +++
 rtl/mmio_counters.sv | 113 +++++++++++
 tb/tb_mmio_counters.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_counters_pkg.sv
// Shared MMIO counter address map and register-select decode.
// Branch counter words are decoded only when the caller enables them.
package mmio_counters_pkg;

  localparam logic [3:0]  MMIO_REGION    = 4'h8;
  localparam logic [27:0] MMIO_CYCLE_CNT = 28'h10;
  localparam logic [27:0] MMIO_INST_CNT  = 28'h14;
  localparam logic [27:0] MMIO_CNTR_RST  = 28'h18;
  localparam logic [27:0] MMIO_BR_CNT    = 28'h1C;
  localparam logic [27:0] MMIO_BR_OK_CNT = 28'h20;

  typedef enum logic [2:0] {
    SelNone,
    SelCycle,
    SelInst,
    SelClr,
    SelBr,
    SelBrOk
  } mmio_sel_e;

  // Byte lane bits are dropped; all mapped words are word aligned.
  function automatic mmio_sel_e mmio_decode(logic [27:0] off, logic br_en);
    logic [27:0] word;
    word = {off[27:2], 2'b00};
    case (word)
      MMIO_CYCLE_CNT: return SelCycle;
      MMIO_INST_CNT:  return SelInst;
      MMIO_CNTR_RST:  return SelClr;
      MMIO_BR_CNT:    return br_en ? SelBr : SelNone;
      MMIO_BR_OK_CNT: return br_en ? SelBrOk : SelNone;
      default:        return SelNone;
    endcase
  endfunction

endpackage

// File: rtl/mmio_cntr.sv
// Free-running wrap-around counter with synchronous reset and clear.
module mmio_cntr #(
  parameter int unsigned CNTR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  inc_i,
  output logic [CNTR_WIDTH-1:0] cnt_o
);

  logic [CNTR_WIDTH-1:0] cnt_d, cnt_q;

  // Clear beats a same-cycle increment; overflow wraps silently.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mmio_counters.sv
// MMIO performance counters: cycle and retired-instruction counts, plus a
// branch/branch-correct pair when MMIO_BRANCH_CNTR_EN is defined.
module mmio_counters
  import mmio_counters_pkg::*;
#(
  parameter int unsigned CNTR_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           addr_i,
  input  logic                  re_i,
  input  logic                  we_i,
  input  logic                  inst_retire_i,
  input  logic                  br_retire_i,
  input  logic                  br_correct_i,
  output logic [CNTR_WIDTH-1:0] rdata_o,
  output logic                  hit_o
);

`ifdef MMIO_BRANCH_CNTR_EN
  localparam logic BrEn = 1'b1;
`else
  localparam logic BrEn = 1'b0;
`endif

  mmio_sel_e             sel;
  logic                  clr;
  logic [CNTR_WIDTH-1:0] cycle_cnt, inst_cnt;
  logic [CNTR_WIDTH-1:0] rdata_d, rdata_q;

  assign sel   = (addr_i[31:28] == BASE_ADDR[31:28]) ? mmio_decode(addr_i[27:0], BrEn)
                                                      : SelNone;
  assign hit_o = (sel != SelNone);
  assign clr   = we_i && (sel == SelClr);

  mmio_cntr #(
    .CNTR_WIDTH(CNTR_WIDTH)
  ) u_cycle_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(clr),
    .inc_i(1'b1),
    .cnt_o(cycle_cnt)
  );

  mmio_cntr #(
    .CNTR_WIDTH(CNTR_WIDTH)
  ) u_inst_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(clr),
    .inc_i(inst_retire_i),
    .cnt_o(inst_cnt)
  );

`ifdef MMIO_BRANCH_CNTR_EN
  logic [CNTR_WIDTH-1:0] br_cnt, br_ok_cnt;

  mmio_cntr #(
    .CNTR_WIDTH(CNTR_WIDTH)
  ) u_br_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(clr),
    .inc_i(br_retire_i),
    .cnt_o(br_cnt)
  );

  mmio_cntr #(
    .CNTR_WIDTH(CNTR_WIDTH)
  ) u_br_ok_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(clr),
    .inc_i(br_retire_i && br_correct_i),
    .cnt_o(br_ok_cnt)
  );
`else
  logic unused_br;
  assign unused_br = ^{br_retire_i, br_correct_i};
`endif

  // Reads capture the pre-edge count; a colliding store forces zero.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = '0;
      if (!we_i) begin
        case (sel)
          SelCycle: rdata_d = cycle_cnt;
          SelInst:  rdata_d = inst_cnt;
`ifdef MMIO_BRANCH_CNTR_EN
          SelBr:    rdata_d = br_cnt;
          SelBrOk:  rdata_d = br_ok_cnt;
`endif
          default:  rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_mmio_counters.sv
// Bench for mmio_counters: a 32-bit instance and a 4-bit instance for quick wrap coverage.
module tb_mmio_counters;
  import mmio_counters_pkg::*;

`ifdef MMIO_BRANCH_CNTR_EN
  localparam bit Feat = 1'b1;
`else
  localparam bit Feat = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic        re = 1'b0, we = 1'b0, ir = 1'b0, brr = 1'b0, brc = 1'b0;
  logic [31:0] rdata;
  logic [3:0]  rdata_s;
  logic        hit, hit_s;

  int checks = 0;
  int failures = 0;

  // Reference state: counts as plain integers, wrapped by variable width.
  logic [31:0] m_cyc = '0, m_inst = '0, m_br = '0, m_bok = '0, m_rd = '0;
  logic [3:0]  s_cyc = '0, s_inst = '0, s_br = '0, s_bok = '0, s_rd = '0;

  always #5 clk = ~clk;

  mmio_counters u_dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .re_i(re), .we_i(we),
    .inst_retire_i(ir), .br_retire_i(brr), .br_correct_i(brc),
    .rdata_o(rdata), .hit_o(hit)
  );

  mmio_counters #(.CNTR_WIDTH(4)) u_dut_s (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .re_i(re), .we_i(we),
    .inst_retire_i(ir), .br_retire_i(brr), .br_correct_i(brc),
    .rdata_o(rdata_s), .hit_o(hit_s)
  );

  typedef struct {
    logic [31:0] addr;
    bit          exp_hit;
  } dec_vec_t;
  dec_vec_t dv[13];

  function automatic bit model_hit(logic [31:0] a);
    logic [31:0] w;
    if (a[31:28] != MMIO_REGION) return 1'b0;
    w = a & 32'h0FFF_FFFC;
    return (w == 32'(MMIO_CYCLE_CNT)) || (w == 32'(MMIO_INST_CNT)) ||
           (w == 32'(MMIO_CNTR_RST)) ||
           (Feat && ((w == 32'(MMIO_BR_CNT)) || (w == 32'(MMIO_BR_OK_CNT))));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit          h;
    logic [31:0] w;
    h = model_hit(addr);
    w = addr & 32'h0FFF_FFFC;
    if (rst) begin
      {m_cyc, m_inst, m_br, m_bok, m_rd} = '0;
      {s_cyc, s_inst, s_br, s_bok, s_rd} = '0;
    end else begin
      if (re) begin
        m_rd = '0;
        s_rd = '0;
        if (!we && h) begin
          if (w == 32'h10) begin m_rd = m_cyc; s_rd = s_cyc; end
          if (w == 32'h14) begin m_rd = m_inst; s_rd = s_inst; end
          if (w == 32'h1C) begin m_rd = m_br; s_rd = s_br; end
          if (w == 32'h20) begin m_rd = m_bok; s_rd = s_bok; end
        end
      end
      if (we && h && w == 32'h18) begin
        {m_cyc, m_inst, m_br, m_bok} = '0;
        {s_cyc, s_inst, s_br, s_bok} = '0;
      end else begin
        m_cyc += 1; s_cyc += 1;
        if (ir) begin m_inst += 1; s_inst += 1; end
        if (Feat && brr) begin m_br += 1; s_br += 1; end
        if (Feat && brr && brc) begin m_bok += 1; s_bok += 1; end
      end
    end
  endtask

  // Inputs change 1 after an edge; hit is checked mid-cycle, rdata 1 after the edge.
  task automatic tick();
    #2;
    chk("hit", {31'b0, hit}, {31'b0, model_hit(addr)});
    chk("hit_s", {31'b0, hit_s}, {31'b0, model_hit(addr)});
    @(posedge clk);
    model_edge();
    #1;
    chk("rdata", rdata, m_rd);
    chk("rdata_s", {28'b0, rdata_s}, {28'b0, s_rd});
  endtask

  task automatic set_in(logic r, logic [31:0] a, logic rr, logic ww, logic i, logic b, logic c);
    rst = r; addr = a; re = rr; we = ww; ir = i; brr = b; brc = c;
  endtask

  task automatic rst_pulse();
    set_in(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    dv[0]  = '{32'h8000_0010, 1'b1};
    dv[1]  = '{32'h8000_0013, 1'b1};
    dv[2]  = '{32'h8000_0014, 1'b1};
    dv[3]  = '{32'h8000_0018, 1'b1};
    dv[4]  = '{32'h8000_001C, Feat};
    dv[5]  = '{32'h8000_0020, Feat};
    dv[6]  = '{32'h8000_0030, 1'b0};
    dv[7]  = '{32'h8000_0000, 1'b0};
    dv[8]  = '{32'h9000_0010, 1'b0};
    dv[9]  = '{32'h0000_0014, 1'b0};
    dv[10] = '{32'h8000_000C, 1'b0};
    dv[11] = '{32'h8000_0024, 1'b0};
    dv[12] = '{32'h8000_0110, 1'b0};

    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    tick();
    chk("reset_rdata", rdata, 32'h0);
    rst = 1'b0;

    // Address decode table.
    for (int i = 0; i < 13; i++) begin
      addr = dv[i].addr;
      #1;
      chk("decode_hit", {31'b0, hit}, {31'b0, dv[i].exp_hit});
    end

    // NOP program: clear, 10 retires, read inst then cycle.
    set_in(1'b0, 32'h8000_0018, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, 32'h8000_0014, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("nop_inst", rdata, 32'd10);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 32'h8000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("nop_cycle", rdata, 32'd12);

    // Clear beats same-cycle increments.
    set_in(1'b0, 32'h8000_0018, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 32'h8000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("clr_cycle0", rdata, 32'd0);
    tick();
    chk("clr_cycle1", rdata, 32'd1);
    set_in(1'b0, 32'h8000_0018, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 32'h8000_0014, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("clr_inst0", rdata, 32'd0);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 32'h8000_0014, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("clr_inst1", rdata, 32'd1);

    // Read timing, hold, and unmapped read.
    rst_pulse();
    for (int i = 0; i < 5; i++) tick();
    set_in(1'b0, 32'h8000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("read_cyc5", rdata, 32'd5);
    set_in(1'b0, 32'h8000_0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold", rdata, 32'd5);
    end
    set_in(1'b0, 32'h8000_0030, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("unmapped_hit", {31'b0, hit}, 32'd0);
    chk("unmapped_rdata", rdata, 32'd0);
    set_in(1'b0, 32'h8000_0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("re_we_rdata", rdata, 32'd0);

    // Wrap on the 4-bit instance.
    rst_pulse();
    for (int i = 0; i < 15; i++) tick();
    set_in(1'b0, 32'h8000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("wrap_cyc_f", {28'b0, rdata_s}, 32'd15);
    tick();
    chk("wrap_cyc_0", {28'b0, rdata_s}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, 32'h8000_0014, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("wrap_inst_s", {28'b0, rdata_s}, 32'd0);
    chk("nowrap_inst", rdata, 32'd16);

    // Reset mid-run at cycle 40 / inst 30.
    rst_pulse();
    for (int i = 0; i < 30; i++) begin
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    set_in(1'b0, 32'h8000_0014, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("pre_rst_inst", rdata, 32'd30);
    set_in(1'b1, 32'h8000_0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("rst_rdata", rdata, 32'd0);
    set_in(1'b0, 32'h8000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rst_cycle", rdata, 32'd0);
    set_in(1'b0, 32'h8000_0014, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rst_inst", rdata, 32'd0);

    // Branch counters: 9 retires, 8 correct, one stray br_correct.
    rst_pulse();
    for (int i = 0; i < 9; i++) begin
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, (i < 8) ? 1'b1 : 1'b0);
      tick();
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 32'h8000_001C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("br_hit", {31'b0, hit}, {31'b0, Feat});
    chk("br_cnt", rdata, Feat ? 32'd9 : 32'd0);
    set_in(1'b0, 32'h8000_0020, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("br_ok_cnt", rdata, Feat ? 32'd8 : 32'd0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      set_in(($urandom_range(63) == 0), dv[$urandom_range(12)].addr, 1'($urandom_range(1)),
             ($urandom_range(7) == 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
             1'($urandom_range(1)));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
